ov7670_capture_ctrl: RTL

//  Write-side sequencer for the frame buffer. Samples the OV7670 pixel bus (vsync/href/8-bit data)
//  and pairs bytes into RGB565 pixels. Generates the frame buffer write port (pixel, X, Y, enable),

---
 rtl/ov7670_capture_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_ctrl.sv
// ov7670_capture_ctrl
// Write-side sequencer for the frame buffer, clocked by the camera PCLK.
// It registers the OV7670 bus, pairs bytes into RGB565 pixels and drives the
// frame buffer write port (pixelOut/outX/outY/writeEn). It also runs the
// frame arm/done handshake (busy/frameDone/frameErr).
//
// Handshake: writeEn is a one-cycle strobe with no back-pressure. The buffer
// must accept pixelOut at {outX,outY} in every cycle where writeEn is high.
// frameDone is a one-cycle pulse. busy is a level.
//
// Optional feature: define CAPTURE_TEST_PATTERN_EN to allow testPattern=1 to
// replace camera pixels with {col[4:0], row[5:0], col[9:5]}. The camera still
// paces the writes. Without the macro, testPattern is ignored.
module ov7670_capture_ctrl #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic           writeClk,
    input  logic           resetN,
    input  logic           captureEn,
    input  logic           continuous,
    input  logic           testPattern,
    input  logic           camVsync,
    input  logic           camHref,
    input  logic [7:0]     camData,
    output logic [15:0]    pixelOut,
    output logic [X_W-1:0] outX,
    output logic [Y_W-1:0] outY,
    output logic           writeEn,
    output logic           busy,
    output logic           frameDone,
    output logic           frameErr
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_VS    = 3'd1,
        WAIT_START = 3'd2,
        ACTIVE     = 3'd3,
        DONE       = 3'd4
    } capState_t;

    // One extra bit so that limits equal to 2**X_W or 2**Y_W still fit.
    localparam logic [X_W:0] H_LIM = (X_W+1)'(H_PIXELS);
    localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_LINES);
    localparam logic [X_W-1:0] X_MAX = '1;
    localparam logic [Y_W-1:0] Y_MAX = '1;

    capState_t      state;
    capState_t      stateNext;

    // Registered camera bus and the previous samples used for edge detection.
    logic           vsR;
    logic           hrR;
    logic [7:0]     dR;
    logic           vsP;
    logic           hrP;
    logic           ceP;

    // Byte pairing and line bookkeeping.
    logic           phase;
    logic [7:0]     hiByte;
    logic [X_W-1:0] column;
    logic           linePix;

    // Strobes from the FSM to the datapath.
    logic           armFrame;
    logic           startFrame;
    logic           activeRun;

    logic           vsRise;
    logic           vsFall;
    logic           hrRise;
    logic           hrFall;
    logic           ceRise;
    logic           effPhase;
    logic           inRange;
    logic [15:0]    camPix;
    logic [15:0]    pixSel;

    assign vsRise   = vsR & ~vsP;
    assign vsFall   = ~vsR & vsP;
    assign hrRise   = hrR & ~hrP;
    assign hrFall   = ~hrR & hrP;
    assign ceRise   = captureEn & ~ceP;
    // The first byte of a line arrives together with the href rising edge,
    // so that byte is always treated as a high byte.
    assign effPhase = hrRise ? 1'b0 : phase;
    assign inRange  = ({1'b0, column} < H_LIM) && ({1'b0, outY} < V_LIM);
    assign camPix   = {hiByte, dR};

`ifdef CAPTURE_TEST_PATTERN_EN
    logic [9:0]     patCol;
    assign patCol = 10'(column);

    // Choose between camera data and the coordinate test pattern.
    always_comb begin
        pixSel = camPix;
        if (testPattern) begin
            pixSel = {patCol[4:0], outY[5:0], patCol[9:5]};
        end
    end
`else
    logic           unusedTestPattern;
    assign unusedTestPattern = testPattern;

    // Without the pattern generator the pixel is always camera data.
    always_comb begin
        pixSel = camPix;
    end
`endif

    // FSM state register.
    always_ff @(posedge writeClk) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next state and datapath strobes.
    always_comb begin
        stateNext  = state;
        armFrame   = 1'b0;
        startFrame = 1'b0;
        activeRun  = 1'b0;
        case (state)
            IDLE: begin
                if (continuous ? captureEn : ceRise) begin
                    stateNext = WAIT_VS;
                    armFrame  = 1'b1;
                end
            end
            WAIT_VS: begin
                if (!captureEn) begin
                    stateNext = IDLE;
                end else if (vsR) begin
                    stateNext = WAIT_START;
                end
            end
            WAIT_START: begin
                if (vsFall) begin
                    if (captureEn) begin
                        stateNext  = ACTIVE;
                        startFrame = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            ACTIVE: begin
                // A vsync rise ends the frame. Any byte seen in the same
                // cycle belongs to the discarded partial line.
                if (vsRise) begin
                    stateNext = DONE;
                end else begin
                    activeRun = 1'b1;
                end
            end
            DONE: begin
                if (continuous && captureEn) begin
                    stateNext = WAIT_VS;
                    armFrame  = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Input registers, edge history, byte pairing, counters and outputs.
    always_ff @(posedge writeClk) begin
        if (!resetN) begin
            vsR       <= 1'b0;
            hrR       <= 1'b0;
            dR        <= 8'h00;
            vsP       <= 1'b0;
            hrP       <= 1'b0;
            ceP       <= 1'b0;
            phase     <= 1'b0;
            hiByte    <= 8'h00;
            column    <= '0;
            linePix   <= 1'b0;
            pixelOut  <= 16'h0000;
            outX      <= '0;
            outY      <= '0;
            writeEn   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
            frameErr  <= 1'b0;
        end else begin
            vsR       <= camVsync;
            hrR       <= camHref;
            dR        <= camData;
            vsP       <= vsR;
            hrP       <= hrR;
            ceP       <= captureEn;
            writeEn   <= 1'b0;
            busy      <= (stateNext != IDLE);
            frameDone <= (stateNext == DONE);

            if (armFrame) begin
                frameErr <= 1'b0;
            end

            if (startFrame) begin
                outY     <= '0;
                column   <= '0;
                phase    <= 1'b0;
                linePix  <= 1'b0;
                frameErr <= 1'b0;
            end

            // A frame cut off in the middle of a line is flagged.
            if (state == ACTIVE && vsRise && hrR) begin
                frameErr <= 1'b1;
            end

            if (activeRun) begin
                if (hrR) begin
                    if (!effPhase) begin
                        hiByte <= dR;
                        phase  <= 1'b1;
                        if (hrRise) begin
                            column  <= '0;
                            linePix <= 1'b0;
                        end
                    end else begin
                        // The pixel is consumed even when it is out of range.
                        phase   <= 1'b0;
                        linePix <= 1'b1;
                        if (column != X_MAX) begin
                            column <= column + X_W'(1);
                        end
                        if (inRange) begin
                            writeEn  <= 1'b1;
                            pixelOut <= pixSel;
                            outX     <= column;
                        end else begin
                            frameErr <= 1'b1;
                        end
                    end
                end else if (hrFall && linePix && outY != Y_MAX) begin
                    // Lines that produced no pixel do not advance the row.
                    outY <= outY + Y_W'(1);
                end
            end
        end
    end

endmodule
